// File: rtl/branch_pkg.sv
// branch_pkg: MIPS branch decode constants, PC-source encodings and BHT counter helpers.
package branch_pkg;
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [1:0] CTR_RESET  = 2'b01;
    typedef enum logic [1:0] {
        SEL_PC4    = 2'b00,
        SEL_JUMP   = 2'b01,
        SEL_BRANCH = 2'b10,
        SEL_REG    = 2'b11
    } sel_op_e;
    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic up);
        return up ? (c == 2'b11 ? c : c + 2'd1) : (c == 2'b00 ? c : c - 2'd1);
    endfunction
endpackage

// File: rtl/branch_predict_unit_if.sv
// branch_predict_unit_if: fetch lookup, resolve-stage inputs and registered results.
interface branch_predict_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] if_pc;
    logic              if_pred_taken;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [31:0]       id_instruction;
    logic              id_pred_taken;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic              control;
    logic              stall;
    logic              res_valid;
    logic              branchFlag;
    logic              mispredict;
    logic [1:0]        SEL_OP;
    logic [CNT_W-1:0]  branch_count;
    logic [CNT_W-1:0]  mispredict_count;
    modport master (
        output if_pc, id_valid, id_pc, id_instruction, id_pred_taken, rs, rt, control, stall,
        input  if_pred_taken, res_valid, branchFlag, mispredict, SEL_OP, branch_count, mispredict_count
    );
    modport slave (
        input  if_pc, id_valid, id_pc, id_instruction, id_pred_taken, rs, rt, control, stall,
        output if_pred_taken, res_valid, branchFlag, mispredict, SEL_OP, branch_count, mispredict_count
    );
endinterface

// File: rtl/bht_2bit.sv
// bht_2bit: table of 2-bit saturating counters, one read port and one write port.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             we,
    input  logic             taken,
    output logic             pred
);
    logic [1:0] cnt [DEPTH];
    // Read is straight from the array, so a same-cycle write is not bypassed.
    assign pred = cnt[rd_idx][1];
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) cnt[i] <= CTR_RESET;
        end else if (we) begin
            cnt[wr_idx] <= ctr_next(cnt[wr_idx], taken);
        end
    end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: resolves MIPS branches/jumps one cycle after decode and
// trains a 2-bit BHT used for fetch-stage prediction.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input logic Clk,
    input logic Reset,
    branch_predict_unit_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt_f;
    logic       rs_neg;
    logic       rs_zero;
    logic       cond;
    logic       taken;
    logic       upd;
    logic       misp;
    sel_op_e    sel;
    logic       unused_bits;
    assign opcode      = bus.id_instruction[31:26];
    assign rt_f        = bus.id_instruction[20:16];
    assign funct       = bus.id_instruction[5:0];
    assign rs_neg      = bus.rs[DATA_W-1];
    assign rs_zero     = bus.rs == '0;
    assign unused_bits = &{1'b0, bus.id_instruction[25:21], bus.id_instruction[15:6], bus.if_pc, bus.id_pc};
    always_comb begin
        cond  = 1'b0;
        taken = 1'b0;
        sel   = SEL_PC4;
        if (bus.control) begin
            case (opcode)
                OP_BEQ:      begin cond = 1'b1; taken = bus.rs == bus.rt; end
                OP_BNE:      begin cond = 1'b1; taken = bus.rs != bus.rt; end
                OP_BLEZ:     begin cond = 1'b1; taken = rs_neg | rs_zero; end
                OP_BGTZ:     begin cond = 1'b1; taken = !rs_neg && !rs_zero; end
                OP_REGIMM:   begin
                    cond  = rt_f == RT_BLTZ || rt_f == RT_BGEZ;
                    taken = rt_f == RT_BLTZ ? rs_neg : rt_f == RT_BGEZ && !rs_neg;
                end
                OP_J, OP_JAL: sel = SEL_JUMP;
                OP_SPECIAL:   sel = (funct == FN_JR || funct == FN_JALR) ? SEL_REG : SEL_PC4;
                default:      ;
            endcase
            if (taken) sel = SEL_BRANCH;
        end
    end
    assign upd  = bus.id_valid && !bus.stall && !Reset && cond;
    assign misp = upd && (taken ^ bus.id_pred_taken);
    bht_2bit #(.DEPTH(BHT_DEPTH), .IDX_W(IDX_W)) u_bht (
        .Clk    (Clk),
        .Reset  (Reset),
        .rd_idx (bus.if_pc[IDX_W+1:2]),
        .wr_idx (bus.id_pc[IDX_W+1:2]),
        .we     (upd),
        .taken  (taken),
        .pred   (bus.if_pred_taken)
    );
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.res_valid        <= 1'b0;
            bus.branchFlag       <= 1'b0;
            bus.mispredict       <= 1'b0;
            bus.SEL_OP           <= SEL_PC4;
            bus.branch_count     <= '0;
            bus.mispredict_count <= '0;
        end else if (!bus.stall) begin
            bus.res_valid  <= bus.id_valid;
            bus.branchFlag <= bus.id_valid && taken;
            bus.SEL_OP     <= bus.id_valid ? sel : SEL_PC4;
            bus.mispredict <= misp;
            if (upd && bus.branch_count != '1) bus.branch_count <= bus.branch_count + CNT_W'(1);
            if (misp && bus.mispredict_count != '1) bus.mispredict_count <= bus.mispredict_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: vector table with scoreboard queue plus hand sequences for stall/reset/bypass.
module tb_branch_predict_unit;
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] pc;
        logic        pred;
        logic        ctrl;
        logic        flag;
        logic [1:0]  sel;
        logic        misp;
        logic        cond;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    vec_t tv[$];
    vec_t sb[$];
    logic [1:0]  m_bht [16];
    logic [15:0] m_bcnt;
    logic [15:0] m_mcnt;
    branch_predict_unit_if bus ();
    branch_predict_unit dut (.Clk(clk), .Reset(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rtf, input logic [5:0] fn);
        return {op, 5'd0, rtf, 10'd0, fn};
    endfunction
    function automatic void add(input string n, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] pc, input logic pred, input logic ctrl, input logic flag,
                                input logic [1:0] sel, input logic misp, input logic cond);
        vec_t v;
        v.name = n; v.instr = i; v.rs = a; v.rt = b; v.pc = pc; v.pred = pred; v.ctrl = ctrl;
        v.flag = flag; v.sel = sel; v.misp = misp; v.cond = cond;
        tv.push_back(v);
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask
    task automatic model_reset();
        m_bcnt = '0;
        m_mcnt = '0;
        for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
    endtask
    task automatic chk_outs(input string n, input logic v, input logic f, input logic [1:0] s, input logic m);
        chk({n, "_valid"}, 32'(bus.res_valid), 32'(v));
        chk({n, "_flag"}, 32'(bus.branchFlag), 32'(f));
        chk({n, "_sel"}, 32'(bus.SEL_OP), 32'(s));
        chk({n, "_misp"}, 32'(bus.mispredict), 32'(m));
        chk({n, "_bcnt"}, 32'(bus.branch_count), 32'(m_bcnt));
        chk({n, "_mcnt"}, 32'(bus.mispredict_count), 32'(m_mcnt));
    endtask
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        #1 chk_outs("reset", 0, 0, 2'b00, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask
    // Starts and ends on a falling edge; one resolution per call.
    task automatic drive(input vec_t v);
        vec_t e;
        logic [3:0] i;
        bus.id_valid = 1'b1; bus.id_instruction = v.instr; bus.rs = v.rs; bus.rt = v.rt;
        bus.id_pc = v.pc; bus.if_pc = v.pc; bus.id_pred_taken = v.pred; bus.control = v.ctrl; bus.stall = 1'b0;
        i = v.pc[5:2];
        #1 chk({v.name, "_ifpred"}, 32'(bus.if_pred_taken), 32'(m_bht[i][1]));
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.cond) begin
            m_bht[i] = e.flag ? (m_bht[i] == 2'b11 ? 2'b11 : m_bht[i] + 2'd1)
                              : (m_bht[i] == 2'b00 ? 2'b00 : m_bht[i] - 2'd1);
            if (m_bcnt != 16'hffff) m_bcnt++;
            if (e.misp && m_mcnt != 16'hffff) m_mcnt++;
        end
        chk_outs(e.name, 1, e.flag, e.sel, e.misp);
        bus.id_valid = 1'b0;
        @(negedge clk);
    endtask
    initial begin
        bus.if_pc = '0; bus.id_valid = 1'b0; bus.id_pc = '0; bus.id_instruction = '0; bus.id_pred_taken = 1'b0;
        bus.rs = '0; bus.rt = '0; bus.control = 1'b0; bus.stall = 1'b0;
        add("beq_eq",    ins(6'h04, 5'd0, 6'd0), 32'd5,          32'd5, 32'h40, 0, 1, 1, 2'b10, 1, 1);
        add("bgez_neg",  ins(6'h01, 5'd1, 6'd0), 32'hFFFFFFFF,   32'd0, 32'h44, 0, 1, 0, 2'b00, 0, 1);
        add("bltz_neg",  ins(6'h01, 5'd0, 6'd0), 32'hFFFFFFFF,   32'd0, 32'h48, 1, 1, 1, 2'b10, 0, 1);
        add("regimm_3",  ins(6'h01, 5'd3, 6'd0), 32'hFFFFFFFF,   32'd0, 32'h4c, 1, 1, 0, 2'b00, 0, 0);
        add("jr",        ins(6'h00, 5'd0, 6'h08), 32'd0,         32'd0, 32'h50, 1, 1, 0, 2'b11, 0, 0);
        add("jalr",      ins(6'h00, 5'd0, 6'h09), 32'd0,         32'd0, 32'h54, 0, 1, 0, 2'b11, 0, 0);
        add("nop",       32'h0,                   32'd0,         32'd0, 32'h58, 0, 1, 0, 2'b00, 0, 0);
        add("jal",       ins(6'h03, 5'd0, 6'd0),  32'd0,         32'd0, 32'h5c, 1, 1, 0, 2'b01, 0, 0);
        add("j",         ins(6'h02, 5'd0, 6'd0),  32'd0,         32'd0, 32'h60, 0, 1, 0, 2'b01, 0, 0);
        add("bne_ne",    ins(6'h05, 5'd0, 6'd0),  32'd1,         32'd2, 32'h64, 0, 1, 1, 2'b10, 1, 1);
        add("bne_eq",    ins(6'h05, 5'd0, 6'd0),  32'd3,         32'd3, 32'h68, 0, 1, 0, 2'b00, 0, 1);
        add("blez_zero", ins(6'h06, 5'd0, 6'd0),  32'd0,         32'd0, 32'h6c, 1, 1, 1, 2'b10, 0, 1);
        add("blez_pos",  ins(6'h06, 5'd0, 6'd0),  32'd1,         32'd0, 32'h6c, 1, 1, 0, 2'b00, 1, 1);
        add("bgtz_min",  ins(6'h07, 5'd0, 6'd0),  32'h80000000,  32'd0, 32'h70, 0, 1, 0, 2'b00, 0, 1);
        add("bgtz_pos",  ins(6'h07, 5'd0, 6'd0),  32'd7,         32'd0, 32'h74, 0, 1, 1, 2'b10, 1, 1);
        add("beq_ctrl0", ins(6'h04, 5'd0, 6'd0),  32'd5,         32'd5, 32'h78, 1, 0, 0, 2'b00, 0, 0);
        add("addi",      ins(6'h08, 5'd0, 6'd0),  32'd5,         32'd5, 32'h7c, 0, 1, 0, 2'b00, 0, 0);
        add("beq_ne",    ins(6'h04, 5'd0, 6'd0),  32'd1,         32'd2, 32'h44, 1, 1, 0, 2'b00, 1, 1);
        add("bgez_zero", ins(6'h01, 5'd1, 6'd0),  32'd0,         32'd0, 32'h48, 0, 1, 1, 2'b10, 1, 1);
        repeat (2) @(posedge clk);
        model_reset();
        #1 chk_outs("reset0", 0, 0, 2'b00, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < tv.size(); k++) drive(tv[k]);
        bus.if_pc = 32'h40;
        #1 chk("beq_trained_0x40", 32'(bus.if_pred_taken), 32'd1);
        @(negedge clk);
        // saturation at pc 0x80
        do_reset();
        for (int k = 0; k < 5; k++)
            drive('{"bne_sat", ins(6'h05, 5'd0, 6'd0), 32'd1, 32'd2, 32'h80, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1});
        drive('{"bne_nt", ins(6'h05, 5'd0, 6'd0), 32'd4, 32'd4, 32'h80, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1});
        bus.if_pc = 32'h80;
        #1 chk("sat_still_taken", 32'(bus.if_pred_taken), 32'd1);
        chk("sat_bcnt6", 32'(bus.branch_count), 32'd6);
        chk("sat_ctr_10", 32'(m_bht[0]), 32'd2);
        @(negedge clk);
        // same-index update and lookup: no bypass
        do_reset();
        bus.id_valid = 1'b1; bus.id_instruction = ins(6'h04, 5'd0, 6'd0); bus.rs = 32'd5; bus.rt = 32'd5;
        bus.id_pc = 32'h40; bus.if_pc = 32'h80; bus.id_pred_taken = 1'b0; bus.control = 1'b1; bus.stall = 1'b0;
        #1 chk("nobypass_old", 32'(bus.if_pred_taken), 32'd0);
        @(posedge clk);
        m_bht[0] = 2'b10; m_bcnt = 16'd1; m_mcnt = 16'd1;
        #1 chk("nobypass_new", 32'(bus.if_pred_taken), 32'd1);
        chk_outs("nobypass_res", 1, 1, 2'b10, 1);
        // stall freezes outputs, counters and table despite a not-taken branch presented
        bus.stall = 1'b1; bus.id_instruction = ins(6'h05, 5'd0, 6'd0); bus.id_pred_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 chk_outs("stall", 1, 1, 2'b10, 1);
            chk("stall_bht", 32'(bus.if_pred_taken), 32'd1);
        end
        bus.stall = 1'b0; bus.id_valid = 1'b0;
        @(posedge clk);
        #1 chk_outs("idle", 0, 0, 2'b00, 0);
        chk("post_stall_bht", 32'(bus.if_pred_taken), 32'd1);
        @(negedge clk);
        // reset dominates a pending resolution and stall
        drive('{"pre_rst", ins(6'h04, 5'd0, 6'd0), 32'd5, 32'd5, 32'h40, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1});
        chk("pre_rst_valid", 32'(bus.res_valid), 32'd1);
        rst = 1'b1; bus.stall = 1'b1; bus.id_valid = 1'b1; bus.if_pc = 32'h40;
        @(posedge clk);
        model_reset();
        #1 chk_outs("rst_dom", 0, 0, 2'b00, 0);
        chk("rst_bht", 32'(bus.if_pred_taken), 32'd0);
        rst = 1'b0; bus.stall = 1'b0; bus.id_valid = 1'b0;
        @(negedge clk);
        drive('{"post_rst", ins(6'h04, 5'd0, 6'd0), 32'd5, 32'd5, 32'h40, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1});
        bus.if_pc = 32'h40;
        #1 chk("post_rst_ctr01", 32'(bus.if_pred_taken), 32'd1);
        if (sb.size() != 0) chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter DATA_W, default 32: width of the rs/rt operands.
REQ-002 Parameter ADDR_W, default 32: PC width.
REQ-003 Parameter BHT_DEPTH, default 16: number of 2-bit counters; SHALL be a power of 2 and at least 2. IDX_W = log2(BHT_DEPTH).
REQ-004 Parameter CNT_W, default 16: width of the statistics counters.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-high. Ports are Clk and Reset.
REQ-006 Clk  in  1  clock.
REQ-007 Reset  in  1  synchronous active-high reset.
REQ-008 if_pc  in  ADDR_W  fetch-stage PC used for the prediction lookup.
REQ-009 if_pred_taken  out  1  combinational prediction for if_pc.
REQ-010 id_valid  in  1  resolve-stage instruction valid.
REQ-011 id_pc, id_instruction, id_pred_taken  in  ADDR_W/32/1  PC, instruction word, and the prediction made at fetch.
REQ-012 rs, rt  in  DATA_W  forwarded operand values.
REQ-013 control  in  1  branch-class enable from the control unit.
REQ-014 stall  in  1  pipeline hold.
REQ-015 res_valid, branchFlag, mispredict  out  1  registered resolution results.
REQ-016 SEL_OP  out  2  registered PC-source select: 00 = PC+4, 01 = jump, 10 = branch, 11 = register (JR/JALR).
REQ-017 branch_count, mispredict_count  out  CNT_W  statistics counters.

Function
REQ-018 Decode fields: opcode = instr[31:26], rt field = instr[20:16], funct = instr[5:0].
REQ-019 Conditional branches, each setting branchFlag=1 and SEL_OP=10 when taken, else 0/00:
- BEQ (000100): rs==rt.
- BNE (000101): rs!=rt.
- BLEZ (000110): rs<=0.
- BGTZ (000111): rs>0.
- REGIMM (000001) with rt field 00001, BGEZ: rs>=0.
- REGIMM (000001) with rt field 00000, BLTZ: rs<0.
REQ-020 All rs comparisons against zero SHALL be signed two's-complement.
REQ-021 REGIMM with any other rt field SHALL decode as a non-branch.
REQ-022 J (000010) and JAL (000011) SHALL give branchFlag=0, SEL_OP=01.
REQ-023 Opcode 000000 with funct 001000 (JR) or 001001 (JALR) SHALL give SEL_OP=11, branchFlag=0. Every other R-type, including 0x00000000, SHALL give SEL_OP=00.
REQ-024 control=0 or an unlisted opcode SHALL resolve as a non-branch: branchFlag=0, SEL_OP=00, no table or counter update.
REQ-025 Resolution latency is 1 cycle. On a rising edge with id_valid=1 and stall=0, the outputs SHALL register the decode results and res_valid SHALL be 1 for that cycle.
REQ-026 On a rising edge with id_valid=0 and stall=0, res_valid, branchFlag and mispredict SHALL be 0 and SEL_OP SHALL be 00.
REQ-027 On a rising edge with stall=1, all registered outputs, BHT entries and counters SHALL hold.
REQ-028 mispredict SHALL be 1 only for a conditional branch (REQ-019) whose actual outcome differs from id_pred_taken. Jumps, JR and non-branches never mispredict.
REQ-029 BHT index = pc[IDX_W+1:2]. Prediction is taken when the counter is 10 or 11.
REQ-030 On each accepted conditional branch, the counter at id_pc's index SHALL saturating-increment if taken, else saturating-decrement. It saturates at 00 and 11.
REQ-031 When the fetch lookup and an update hit the same index in the same cycle, if_pred_taken SHALL reflect the pre-update value (no bypass).
REQ-032 branch_count SHALL increment per accepted conditional branch, and mispredict_count per mispredict. Both saturate at all-ones and do not wrap.

Reset
REQ-033 Reset=1 at a rising edge SHALL set res_valid, branchFlag and mispredict to 0, SEL_OP to 00, both counters to 0, and every BHT entry to 01.
REQ-034 Reset SHALL dominate stall and id_valid. A resolution in flight at reset is discarded, with no update.

Structure
REQ-035 Package branch_pkg SHALL hold:
- opcode, funct and REGIMM rt constants;
- SEL_OP encodings (SEL_PC4, SEL_JUMP, SEL_BRANCH, SEL_REG);
- the counter reset constant 01.
REQ-036 Sub-module bht_2bit SHALL implement the counter table. Ports: Clk, Reset, one read index, one write index, write enable, taken; output prediction.

Verification
REQ-037 After reset, BEQ with rs=5, rt=5, id_pc=0x40, id_pred_taken=0 -> next cycle res_valid=1, branchFlag=1, SEL_OP=10, mispredict=1. Entry 0 goes 01->10, and if_pc=0x40 then predicts taken.
REQ-038 BGEZ with rs=0xFFFFFFFF -> branchFlag=0. BLTZ with the same rs -> branchFlag=1. REGIMM with rt field 00011 -> SEL_OP=00.
REQ-039 JR (funct 0x08) -> SEL_OP=11, branchFlag=0, counters unchanged. Instruction 0x00000000 -> SEL_OP=00. JAL -> SEL_OP=01.
REQ-040 Five taken BNEs at pc 0x80 -> counter holds at 11. One not-taken -> counter 10, prediction still taken. branch_count=6.
REQ-041 stall=1 with id_valid=1 for 3 cycles -> outputs and BHT frozen. Reset asserted while res_valid=1 -> next edge all outputs 0 and entries 01.
REQ-042 BHT_DEPTH=16: an update at pc 0x40 with a simultaneous lookup at pc 0x80 (same index 0) -> if_pred_taken shows the old value, and the new value appears the next cycle.
